// File: rtl/note_highway.sv
// note_highway: four-lane falling-note engine. Scrolls an LFSR-driven note
// pattern toward a strike zone, judges strum edges against that zone and
// keeps saturating hit/miss counts plus a sticky game-over flag.
module note_highway #(
    parameter logic [2:0] PLAY_MODE  = 3'd2,
    parameter logic [2:0] CLEAR_MODE = 3'd0,
    parameter logic [7:0] MAX_MISS   = 8'd20,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic [22:0] diff_speed,
    input  logic [3:0]  strum,
    output logic [31:0] lanes,
    output logic [7:0]  score,
    output logic [7:0]  misses,
    output logic        hit,
    output logic        miss,
    output logic        tick,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_HOLD
    } state_e;

    state_e      state;

    logic [22:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  strum_q, strum_d;
    logic [31:0] lanes_q, lanes_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  misses_q, misses_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        tick_q, tick_d;
    logic        go_q, go_d;

    logic        tick_now;
    logic [3:0]  strum_edge;
    logic [3:0]  spawn;
    logic [3:0]  hit_v;
    logic [3:0]  wrong_v;
    logic [3:0]  out_v;
    logic [31:0] lanes_next;
    logic [2:0]  hit_cnt;
    logic [3:0]  miss_cnt;
    logic [8:0]  score_sum;
    logic [8:0]  miss_sum;
    logic [7:0]  lfsr_next;

    // Decode the operating state from mode and the sticky game-over flag.
    always_comb begin
        state = ST_HOLD;
        if (mode == CLEAR_MODE) begin
            state = ST_CLEAR;
        end else if ((mode == PLAY_MODE) && !go_q) begin
            state = ST_RUN;
        end
    end

    // Per-lane judging and shifting; a note hit on the tick that would shift
    // it out is judged on the pre-tick strike bit and never also counted as a miss.
    always_comb begin
        tick_now   = (cnt_q >= diff_speed);
        strum_edge = strum & ~strum_q;
        spawn      = lfsr_q[7] ? (4'b0001 << lfsr_q[1:0]) : '0;
        lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        hit_v      = '0;
        wrong_v    = '0;
        out_v      = '0;
        lanes_next = lanes_q;
        hit_cnt    = '0;
        miss_cnt   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            hit_v[i]   = strum_edge[i] & lanes_q[8*i];
            wrong_v[i] = strum_edge[i] & ~lanes_q[8*i];
            out_v[i]   = tick_now & lanes_q[8*i] & ~hit_v[i];
            if (tick_now) begin
                lanes_next[8*i +: 8] = {spawn[i], lanes_q[8*i+1 +: 7]};
            end else begin
                lanes_next[8*i +: 8] = lanes_q[8*i +: 8] & ~{7'b0, hit_v[i]};
            end
            hit_cnt  = hit_cnt + {2'b0, hit_v[i]};
            miss_cnt = miss_cnt + {3'b0, wrong_v[i]} + {3'b0, out_v[i]};
        end
        score_sum = {1'b0, score_q} + {6'b0, hit_cnt};
        miss_sum  = {1'b0, misses_q} + {5'b0, miss_cnt};
    end

    // Next-state selection for CLEAR, RUN and HOLD.
    always_comb begin
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        strum_d  = strum;
        lanes_d  = lanes_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        tick_d   = 1'b0;
        go_d     = go_q;
        case (state)
            ST_CLEAR: begin
                cnt_d    = '0;
                lanes_d  = '0;
                score_d  = '0;
                misses_d = '0;
                go_d     = 1'b0;
            end
            ST_RUN: begin
                cnt_d    = tick_now ? '0 : cnt_q + 23'd1;
                tick_d   = tick_now;
                lfsr_d   = tick_now ? lfsr_next : lfsr_q;
                lanes_d  = lanes_next;
                score_d  = score_sum[8] ? 8'hFF : score_sum[7:0];
                misses_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
                hit_d    = (hit_cnt != 3'd0);
                miss_d   = (miss_cnt != 4'd0);
                go_d     = go_q | (misses_q >= MAX_MISS);
            end
            default: ;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            strum_q  <= '0;
            lanes_q  <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            tick_q   <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            strum_q  <= strum_d;
            lanes_q  <= lanes_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            tick_q   <= tick_d;
            go_q     <= go_d;
        end
    end

    assign lanes     = lanes_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign tick      = tick_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_note_highway.sv
// Directed bench for note_highway: three instances share stimulus
// (default MAX_MISS, MAX_MISS=3, MAX_MISS=255).
module tb_note_highway;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [22:0] diff_speed;
    logic [3:0]  strum;

    logic [31:0] m_lanes, g_lanes, s_lanes;
    logic [7:0]  m_score, g_score, s_score;
    logic [7:0]  m_misses, g_misses, s_misses;
    logic        m_hit, g_hit, s_hit;
    logic        m_miss, g_miss, s_miss;
    logic        m_tick, g_tick, s_tick;
    logic        m_go, g_go, s_go;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    note_highway dut (
        .clk(clk), .reset(reset), .mode(mode), .diff_speed(diff_speed), .strum(strum),
        .lanes(m_lanes), .score(m_score), .misses(m_misses), .hit(m_hit),
        .miss(m_miss), .tick(m_tick), .game_over(m_go)
    );

    note_highway #(.MAX_MISS(8'd3)) dut_g (
        .clk(clk), .reset(reset), .mode(mode), .diff_speed(diff_speed), .strum(strum),
        .lanes(g_lanes), .score(g_score), .misses(g_misses), .hit(g_hit),
        .miss(g_miss), .tick(g_tick), .game_over(g_go)
    );

    note_highway #(.MAX_MISS(8'd255)) dut_s (
        .clk(clk), .reset(reset), .mode(mode), .diff_speed(diff_speed), .strum(strum),
        .lanes(s_lanes), .score(s_score), .misses(s_misses), .hit(s_hit),
        .miss(s_miss), .tick(s_tick), .game_over(s_go)
    );

    task automatic do_reset(input logic [22:0] spd);
        @(negedge clk);
        reset = 1'b1; mode = 3'd0; strum = '0; diff_speed = spd;
        repeat (2) @(negedge clk);
        reset = 1'b0; mode = 3'd2;
    endtask

    // Waits for the next tick on the default instance; cycles = posedges taken.
    task automatic wait_tick(input int limit, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int c = 1; c <= limit && !seen; c++) begin
            @(posedge clk); #1;
            if (m_tick) begin
                seen = 1'b1;
                cycles = c;
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL tick_timeout: no tick within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1; mode = 3'd0; strum = '0; diff_speed = 23'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0; mode = 3'd2;
        repeat (10) @(negedge clk);
        strum = 4'b0101;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (m_lanes !== 32'h0) begin
            n_fail++; $display("FAIL reset_lanes: got %h expected %h", m_lanes, 32'h0);
        end
        n_tests++;
        if ({m_score, m_misses} !== 16'h0) begin
            n_fail++; $display("FAIL reset_counts: got %h expected %h", {m_score, m_misses}, 16'h0);
        end
        n_tests++;
        if ({m_hit, m_miss, m_tick, m_go} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", {m_hit, m_miss, m_tick, m_go}, 4'b0);
        end
        // Partial count before a second reset must be discarded.
        @(negedge clk);
        reset = 1'b0; strum = '0; diff_speed = 23'd3;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_tick(20, c);
        n_tests++;
        if (c !== 4) begin
            n_fail++; $display("FAIL first_tick_latency: got %0d expected %0d", c, 4);
        end
        n_tests++;
        if (m_lanes !== 32'h0000_8000) begin
            n_fail++; $display("FAIL first_spawn: got %h expected %h", m_lanes, 32'h0000_8000);
        end
        wait_tick(20, c);
        n_tests++;
        if (c !== 4) begin
            n_fail++; $display("FAIL tick_period: got %0d expected %0d", c, 4);
        end
        n_tests++;
        if (m_lanes !== 32'h0000_4000) begin
            n_fail++; $display("FAIL second_tick_lanes: got %h expected %h", m_lanes, 32'h0000_4000);
        end
    endtask

    task automatic test_scroll_miss();
        int c;
        do_reset(23'd3);
        for (int k = 0; k < 8; k++) wait_tick(20, c);
        n_tests++;
        if ({m_lanes, m_misses} !== {32'h8000_2500, 8'd0}) begin
            n_fail++; $display("FAIL scroll_tick8: got %h expected %h", {m_lanes, m_misses}, {32'h8000_2500, 8'd0});
        end
        wait_tick(20, c);
        n_tests++;
        if ({m_lanes, m_misses, m_miss} !== {32'h4000_1200, 8'd1, 1'b1}) begin
            n_fail++; $display("FAIL scroll_shiftout: got %h expected %h", {m_lanes, m_misses, m_miss}, {32'h4000_1200, 8'd1, 1'b1});
        end
        @(posedge clk); #1;
        n_tests++;
        if (m_miss !== 1'b0) begin
            n_fail++; $display("FAIL miss_pulse_width: got %b expected %b", m_miss, 1'b0);
        end
    endtask

    task automatic test_hit();
        int c;
        do_reset(23'd3);
        for (int k = 0; k < 8; k++) wait_tick(20, c);
        // Lane 1 strike bit set, lane 3 strike bit clear: one hit and one wrong press.
        @(negedge clk); strum = 4'b1010;
        @(posedge clk); #1;
        n_tests++;
        if ({m_hit, m_miss, m_score, m_misses, m_lanes} !== {1'b1, 1'b1, 8'd1, 8'd1, 32'h8000_2400}) begin
            n_fail++; $display("FAIL hit_and_wrong: got %h expected %h", {m_hit, m_miss, m_score, m_misses, m_lanes}, {1'b1, 1'b1, 8'd1, 8'd1, 32'h8000_2400});
        end
        @(posedge clk); #1;
        n_tests++;
        if ({m_hit, m_miss, m_score} !== {1'b0, 1'b0, 8'd1}) begin
            n_fail++; $display("FAIL hold_no_rehit: got %h expected %h", {m_hit, m_miss, m_score}, {1'b0, 1'b0, 8'd1});
        end
        wait_tick(20, c);
        n_tests++;
        if ({m_lanes, m_score, m_misses, m_hit, m_miss} !== {32'h4000_1200, 8'd1, 8'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL hit_note_not_missed: got %h expected %h", {m_lanes, m_score, m_misses, m_hit, m_miss}, {32'h4000_1200, 8'd1, 8'd1, 1'b0, 1'b0});
        end
        @(negedge clk); strum = 4'b1011;
        @(posedge clk); #1;
        n_tests++;
        if ({m_hit, m_miss, m_score, m_misses} !== {1'b0, 1'b1, 8'd1, 8'd2}) begin
            n_fail++; $display("FAIL empty_lane_press: got %h expected %h", {m_hit, m_miss, m_score, m_misses}, {1'b0, 1'b1, 8'd1, 8'd2});
        end
    endtask

    task automatic test_same_cycle();
        int c;
        do_reset(23'd3);
        for (int k = 0; k < 8; k++) wait_tick(20, c);
        repeat (3) @(posedge clk);
        @(negedge clk); strum = 4'b0010;
        @(posedge clk); #1;
        n_tests++;
        if ({m_tick, m_hit, m_miss, m_score, m_misses, m_lanes} !== {1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 32'h4000_1200}) begin
            n_fail++; $display("FAIL same_cycle_tick_hit: got %h expected %h", {m_tick, m_hit, m_miss, m_score, m_misses, m_lanes}, {1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 32'h4000_1200});
        end
    endtask

    task automatic test_pause_clear();
        int c;
        do_reset(23'd3);
        wait_tick(20, c);
        repeat (2) @(posedge clk);
        @(negedge clk); mode = 3'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            strum = ((i % 2) == 0 && i < 18) ? 4'hF : 4'h0;
            @(posedge clk); #1;
            n_tests++;
            if ({m_tick, m_hit, m_miss, m_lanes, m_score, m_misses} !== {3'b000, 32'h0000_8000, 8'd0, 8'd0}) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: got %h expected %h", i, {m_tick, m_hit, m_miss, m_lanes, m_score, m_misses}, {3'b000, 32'h0000_8000, 8'd0, 8'd0});
            end
        end
        @(negedge clk); strum = '0; mode = 3'd2;
        wait_tick(20, c);
        n_tests++;
        if ({c[7:0], m_lanes} !== {8'd2, 32'h0000_4000}) begin
            n_fail++; $display("FAIL resume_count: got %h expected %h", {c[7:0], m_lanes}, {8'd2, 32'h0000_4000});
        end
        @(negedge clk); strum = 4'b0001;
        @(posedge clk); #1;
        n_tests++;
        if (m_misses !== 8'd1) begin
            n_fail++; $display("FAIL pre_clear_miss: got %0d expected %0d", m_misses, 1);
        end
        @(negedge clk); strum = '0; mode = 3'd0;
        @(posedge clk); #1;
        n_tests++;
        if ({m_lanes, m_score, m_misses, m_tick, m_go} !== {32'h0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL clear_state: got %h expected %h", {m_lanes, m_score, m_misses, m_tick, m_go}, {32'h0, 8'd0, 8'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_game_over();
        do_reset(23'h7FFFFF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); strum = 4'b0001;
            @(negedge clk); strum = 4'b0000;
        end
        @(negedge clk); strum = 4'b0001;
        @(posedge clk); #1;
        n_tests++;
        if ({g_misses, g_go} !== {8'd3, 1'b0}) begin
            n_fail++; $display("FAIL go_not_yet: got %h expected %h", {g_misses, g_go}, {8'd3, 1'b0});
        end
        @(negedge clk); strum = 4'b0000;
        @(posedge clk); #1;
        n_tests++;
        if (g_go !== 1'b1) begin
            n_fail++; $display("FAIL go_set: got %b expected %b", g_go, 1'b1);
        end
        @(negedge clk); diff_speed = 23'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({g_tick, m_tick, g_lanes} !== {1'b0, 1'b1, 32'h0}) begin
                n_fail++; $display("FAIL go_scroll_stopped[%0d]: got %h expected %h", i, {g_tick, m_tick, g_lanes}, {1'b0, 1'b1, 32'h0});
            end
        end
        @(negedge clk); strum = 4'b0001;
        @(posedge clk); #1;
        n_tests++;
        if ({g_misses, g_miss} !== {8'd3, 1'b0}) begin
            n_fail++; $display("FAIL go_press_ignored: got %h expected %h", {g_misses, g_miss}, {8'd3, 1'b0});
        end
        @(negedge clk); strum = '0; mode = 3'd0;
        @(posedge clk); #1;
        n_tests++;
        if ({g_go, g_misses} !== {1'b0, 8'd0}) begin
            n_fail++; $display("FAIL go_cleared: got %h expected %h", {g_go, g_misses}, {1'b0, 8'd0});
        end
    endtask

    task automatic test_saturation();
        do_reset(23'h7FFFFF);
        for (int k = 0; k < 63; k++) begin
            @(negedge clk); strum = 4'hF;
            @(negedge clk); strum = 4'h0;
        end
        n_tests++;
        if ({s_misses, s_go} !== {8'd252, 1'b0}) begin
            n_fail++; $display("FAIL sat_252: got %h expected %h", {s_misses, s_go}, {8'd252, 1'b0});
        end
        @(negedge clk); strum = 4'hF;
        @(posedge clk); #1;
        n_tests++;
        if ({s_misses, s_miss} !== {8'd255, 1'b1}) begin
            n_fail++; $display("FAIL sat_clamp: got %h expected %h", {s_misses, s_miss}, {8'd255, 1'b1});
        end
        @(negedge clk); strum = 4'h0;
        @(posedge clk); #1;
        n_tests++;
        if (s_go !== 1'b1) begin
            n_fail++; $display("FAIL sat_go: got %b expected %b", s_go, 1'b1);
        end
        @(negedge clk); strum = 4'hF;
        @(posedge clk); #1;
        n_tests++;
        if (s_misses !== 8'd255) begin
            n_fail++; $display("FAIL sat_hold: got %0d expected %0d", s_misses, 255);
        end
        @(negedge clk); strum = 4'h0;
    endtask

    initial begin
        test_reset();
        test_scroll_miss();
        test_hit();
        test_same_cycle();
        test_pause_clear();
        test_game_over();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/note_highway.md
# note_highway

Four-lane falling-note engine for the guitar game, directly downstream of `diff_speed`. It consumes the `mode` from `state_fsm` and the scroll period `diff_speed`. On each scroll tick it shifts a pseudo-random note pattern toward a strike zone. It judges strum presses against that zone and keeps hit and miss counts for the display logic.

## Interface
Parameters:
- `PLAY_MODE`, 3'd2: `mode` value in which notes scroll and presses are judged.
- `CLEAR_MODE`, 3'd0: `mode` value that clears the game state.
- `MAX_MISS`, 8'd20: miss count at which `game_over` asserts.
- `LFSR_SEED`, 8'hA5: LFSR value loaded on reset; must be nonzero.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  3  game mode from `state_fsm`.
- `diff_speed`  in  23  scroll period in clk cycles, from `diff_speed`.
- `strum`  in  4  per-lane strum buttons, level, already synchronized.
- `lanes`  out  32  note grid; lane i = bits [8i+7:8i]; bit 7 = top row, bit 0 = strike zone.
- `score`  out  8  hit count, saturating.
- `misses`  out  8  miss count, saturating.
- `hit`  out  1  one-cycle pulse when at least one note is hit.
- `miss`  out  1  one-cycle pulse when at least one miss is counted.
- `tick`  out  1  one-cycle pulse on each scroll step.
- `game_over`  out  1  sticky; asserts when `misses >= MAX_MISS`.

## Operation
- **Reset.** All outputs 0, tick counter 0, strum history 0, LFSR = `LFSR_SEED`.
- **States.** `CLEAR` (mode==CLEAR_MODE), `RUN` (mode==PLAY_MODE and !game_over), `HOLD` (all other cases).
  - CLEAR: lanes, score, misses, tick counter and game_over go to 0. LFSR holds. Strum history still updates.
  - HOLD: every register holds except strum history. No ticks are issued and no presses are judged.
- **Tick counter** (RUN only). Counts up each cycle.
  - When count >= diff_speed, `tick` pulses and count returns to 0.
  - diff_speed==0 gives a tick every cycle.
  - diff_speed changes mid-count apply immediately, using the same >= compare.
- **LFSR.** 8-bit Fibonacci, taps 8,6,5,4: shift left, new bit0 = b7^b5^b4^b3. It advances once per tick.
- **Spawn.** Uses the pre-advance LFSR value. If lfsr[7]==1, one note spawns in lane lfsr[1:0]; otherwise no note spawns.
- **Shift on tick.** For each lane, lane <= {spawn_i, lane[7:1]}. A bit0 that shifts out still set counts as one miss.
- **Strum.** A rising edge on `strum[i]` is strum[i] & ~strum_q[i], evaluated in RUN only.
  - Edge with lane i bit0 == 1: the note is cleared and counts as a hit.
  - Edge with lane i bit0 == 0: counts as one miss (wrong press).
- **Same-cycle tick and hit.** The hit is judged on the pre-tick bit0, and a hit note is not counted as a miss.
- **Count updates.** Hits and misses within one cycle are summed (0–4 hits; 0–8 misses from shift-outs plus wrong presses). They are added in one update, saturating at 255.
- **Pulses.** `hit` pulses iff the hits added this cycle > 0; `miss` works the same way for misses.
- **Game over.** `game_over` sets the cycle after `misses` reaches >= MAX_MISS. It clears only on reset or CLEAR.

## Timing
- All outputs are registered.
- `tick` is high in the cycle after the counter compare, and `lanes` updates in the same cycle as `tick`.
- Strum edge to hit: a button rising in cycle n is sampled at the end of n. `hit`, `score` and the cleared lane bit are visible in cycle n+1.
- Tick period = diff_speed+1 cycles.
- A `reset` or a mode change takes effect on the next clk edge; a reset mid-tick discards the partial count.

## Test plan
- **Reset/seed.** Reset, then mode=2, diff_speed=3.
  - Tick every 4 cycles.
  - First tick spawns in lane lfsr[1:0] of 8'hA5 = lane 1, since bit7=1; lanes = 32'h0000_8000.
- **Scroll and miss.** Single note, no presses, diff_speed=3.
  - The note reaches bit0 after 7 ticks and shifts out on the 8th.
  - misses=1 and miss pulses on that tick.
- **Hit.** Strum the lane while its bit0=1.
  - score=1, hit pulses once, bit cleared.
  - Holding the button produces no second hit.
  - Strumming an empty lane gives misses+1.
- **Same-cycle.** Strum edge in the same cycle as the tick that would shift the note out.
  - score+1, misses unchanged.
  - Four lanes hit in one cycle gives score+4.
- **Pause/clear.** mode=1 mid-count.
  - lanes, counter and tick stay frozen for 20 cycles, and presses are ignored.
  - mode=0 zeroes lanes, score, misses and game_over.
- **Game over and saturation.** MAX_MISS=3, three wrong presses.
  - game_over=1 one cycle after misses=3, and scrolling stops.
  - With a large MAX_MISS, forcing 260 misses holds misses at 255.
